// File: rtl/gc_pkg.sv
// Shared Global Controller definitions: compare-mode codes used by the
// iteration condition unit and its per-lane comparators.
package gc_pkg;

  localparam int CMP_MODE_W = 3;

  // Mode codes; 6 and 7 are reserved and always report no match.
  localparam logic [CMP_MODE_W-1:0] CMP_EQ = 3'd0;
  localparam logic [CMP_MODE_W-1:0] CMP_NE = 3'd1;
  localparam logic [CMP_MODE_W-1:0] CMP_LT = 3'd2;
  localparam logic [CMP_MODE_W-1:0] CMP_LE = 3'd3;
  localparam logic [CMP_MODE_W-1:0] CMP_GT = 3'd4;
  localparam logic [CMP_MODE_W-1:0] CMP_GE = 3'd5;

endpackage : gc_pkg

// File: rtl/iter_cmp_lane.sv
// One compare lane: purely combinational (iteration variable, bound, mode) -> hit.
// All six relations are derived from a single full-width less-than and an equality.
module iter_cmp_lane
  import gc_pkg::*;
#(
  parameter int ITERATION_VARIABLE_WIDTH = 16,
  parameter bit SIGNED_CMP               = 1'b1
) (
  input  logic [ITERATION_VARIABLE_WIDTH-1:0] iter_var,
  input  logic [ITERATION_VARIABLE_WIDTH-1:0] bound,
  input  logic [CMP_MODE_W-1:0]               mode,
  output logic                                hit
);

  logic eq;
  logic lt;

  assign eq = (iter_var == bound);

  // Signedness is fixed at elaboration, so pick the comparator structurally.
  if (SIGNED_CMP) begin : g_signed
    assign lt = ($signed(iter_var) < $signed(bound));
  end else begin : g_unsigned
    assign lt = (iter_var < bound);
  end

  // Select the relation requested by the lane mode.
  always_comb begin
    // NOTE: assigning a default before the case guarantees no latch is inferred
    // and makes the reserved codes fall through to "no match".
    hit = 1'b0;
    case (mode)
      CMP_EQ:  hit = eq;
      CMP_NE:  hit = ~eq;
      CMP_LT:  hit = lt;
      CMP_LE:  hit = lt | eq;
      CMP_GT:  hit = ~(lt | eq);
      CMP_GE:  hit = ~lt;
      default: hit = 1'b0;
    endcase
  end

endmodule : iter_cmp_lane

// File: rtl/iteration_condition_unit.sv
// Multi-channel iteration condition unit for the Global Controller.
// Holds per-lane bound/mode registers, a one-cycle output pipeline stage,
// sticky hit flags and saturating hit counters feeding loop-exit logic.
module iteration_condition_unit
  import gc_pkg::*;
#(
  parameter int ITERATION_VARIABLE_WIDTH = 16,
  parameter int NUM_CHANNELS             = 4,
  parameter bit SIGNED_CMP               = 1'b1,
  parameter int CNT_WIDTH                = 8,
  localparam int SEL_W = (NUM_CHANNELS > 1) ? $clog2(NUM_CHANNELS) : 1
) (
  input  logic                                         clk,
  input  logic                                         rst,
  input  logic                                         cfg_we,
  input  logic [SEL_W-1:0]                             cfg_sel,
  input  logic [ITERATION_VARIABLE_WIDTH-1:0]          cfg_bound,
  input  logic [CMP_MODE_W-1:0]                        cfg_mode,
  input  logic                                         in_valid,
  input  logic [NUM_CHANNELS*ITERATION_VARIABLE_WIDTH-1:0] in_var,
  input  logic                                         sticky_clr,
  output logic                                         out_valid,
  output logic [NUM_CHANNELS-1:0]                      match,
  output logic                                         any_match,
  output logic                                         all_match,
  output logic [NUM_CHANNELS-1:0]                      sticky,
  output logic [NUM_CHANNELS*CNT_WIDTH-1:0]            hit_cnt
);

  localparam int W = ITERATION_VARIABLE_WIDTH;

  logic [W-1:0]          bound_q [NUM_CHANNELS];
  logic [CMP_MODE_W-1:0] mode_q  [NUM_CHANNELS];
  logic [CNT_WIDTH-1:0]  cnt_q   [NUM_CHANNELS];

  logic [NUM_CHANNELS-1:0] hit_d;
  logic [NUM_CHANNELS-1:0] match_d;
  logic                    out_valid_q;
  logic [NUM_CHANNELS-1:0] match_q;
  logic [NUM_CHANNELS-1:0] sticky_q;

  // Config register file: a write lands on the edge, so a compare issued in the
  // same cycle still sees the old bound/mode. Out-of-range selects match no lane.
  always_ff @(posedge clk) begin
    // NOTE: this small register file is reset on purpose (bounds 0, mode EQ)
    // because downstream logic relies on a defined compare right after reset;
    // it is flops, not a RAM, so resetting it is legal and cheap.
    if (rst) begin
      for (int i = 0; i < NUM_CHANNELS; i++) begin
        bound_q[i] <= '0;
        mode_q[i]  <= CMP_EQ;
      end
    end else begin
      for (int i = 0; i < NUM_CHANNELS; i++) begin
        if (cfg_we && (cfg_sel == SEL_W'(i))) begin
          bound_q[i] <= cfg_bound;
          mode_q[i]  <= cfg_mode;
        end
      end
    end
  end

  for (genvar g = 0; g < NUM_CHANNELS; g++) begin : g_lane
    iter_cmp_lane #(
      .ITERATION_VARIABLE_WIDTH (W),
      .SIGNED_CMP               (SIGNED_CMP)
    ) u_lane (
      .iter_var (in_var[g*W +: W]),
      .bound    (bound_q[g]),
      .mode     (mode_q[g]),
      .hit      (hit_d[g])
    );
  end

  // Results only count when the input is valid; otherwise the stage carries zeros.
  assign match_d = in_valid ? hit_d : '0;

  // Output pipeline stage: one cycle of latency, cleared by reset so an
  // in-flight result is dropped.
  always_ff @(posedge clk) begin
    // NOTE: sequential state is updated with non-blocking assignments so every
    // register samples the pre-edge values regardless of statement order.
    if (rst) begin
      out_valid_q <= 1'b0;
      match_q     <= '0;
    end else begin
      out_valid_q <= in_valid;
      match_q     <= match_d;
    end
  end

  // Sticky flags: a new match wins over a clear arriving in the same cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      sticky_q <= '0;
    end else begin
      sticky_q <= (sticky_q & ~{NUM_CHANNELS{sticky_clr}}) | match_d;
    end
  end

  // Saturating hit counters: a clear restarts at 1 if the lane matches this cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NUM_CHANNELS; i++) begin
        cnt_q[i] <= '0;
      end
    end else begin
      for (int i = 0; i < NUM_CHANNELS; i++) begin
        if (sticky_clr) begin
          cnt_q[i] <= CNT_WIDTH'(match_d[i]);
        end else if (match_d[i] && (cnt_q[i] != '1)) begin
          cnt_q[i] <= cnt_q[i] + 1'b1;
        end
      end
    end
  end

  for (genvar g = 0; g < NUM_CHANNELS; g++) begin : g_cnt_out
    assign hit_cnt[g*CNT_WIDTH +: CNT_WIDTH] = cnt_q[g];
  end

  assign out_valid = out_valid_q;
  assign match     = match_q;
  assign any_match = out_valid_q & (|match_q);
  assign all_match = out_valid_q & (&match_q);
  assign sticky    = sticky_q;

endmodule : iteration_condition_unit
